// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: single-outstanding req/gnt/rvalid fetch, IF/ID register, 1-entry skid.
// Optional stall counter output if_stall_cnt enabled by defining IF_STALL_CNT_EN.
module if_fetch_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_write,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              id_stall,
   input  logic              flush,
   output logic              ifid_valid,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic [ADDR_W-1:0] ifid_pc4
`ifdef IF_STALL_CNT_EN
   ,output logic [31:0]      if_stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_tag_pc;
   logic              r_kill;
   logic              r_skid_vld;
   logic [DATA_W-1:0] r_skid_instr;
   logic [ADDR_W-1:0] r_skid_pc;
   logic              r_ifid_valid;
   logic [DATA_W-1:0] r_ifid_instr;
   logic [ADDR_W-1:0] r_ifid_pc;
   logic [ADDR_W-1:0] r_ifid_pc4;

   logic w_req;
   logic w_accept;
   logic w_deliver;
   logic w_to_skid;

   assign w_req     = ~rst & (r_state == REQ);
   assign w_accept  = (r_state == WAIT) & imem_rvalid;
   assign w_deliver = w_accept & ~r_kill & ~flush;
   // the skid is always empty while a transaction is outstanding
   assign w_to_skid = w_deliver & r_ifid_valid & id_stall;

   assign imem_req   = w_req;
   assign imem_addr  = r_addr;
   assign pc_write   = ~rst & ((w_req & imem_gnt & ~r_kill) | flush);
   assign ifid_valid = r_ifid_valid;
   assign ifid_instr = r_ifid_instr;
   assign ifid_pc    = r_ifid_pc;
   assign ifid_pc4   = r_ifid_pc4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_tag_pc     <= '0;
         r_kill       <= 1'b0;
         r_skid_vld   <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
         r_ifid_pc4   <= '0;
      end else begin
         // a flush holds off REQ entry one cycle so addr latches the redirected PC
         case (r_state)
            IDLE: if (~r_skid_vld & ~flush) begin
               r_state <= REQ;
               r_addr  <= pc_cur;
            end
            REQ: if (imem_gnt) begin
               r_state  <= WAIT;
               r_tag_pc <= r_addr;
            end
            WAIT: if (imem_rvalid) begin
               if (w_to_skid | flush) r_state <= IDLE;
               else begin
                  r_state <= REQ;
                  r_addr  <= pc_cur;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (flush & ((r_state == REQ) | ((r_state == WAIT) & ~imem_rvalid)))
            r_kill <= 1'b1;
         else if (w_accept)
            r_kill <= 1'b0;

         if (flush) begin
            r_ifid_valid <= 1'b0;
            r_skid_vld   <= 1'b0;
         end else if (r_skid_vld) begin
            if (~id_stall) begin
               r_ifid_valid <= 1'b1;
               r_ifid_instr <= r_skid_instr;
               r_ifid_pc    <= r_skid_pc;
               r_ifid_pc4   <= r_skid_pc + ADDR_W'(4);
               r_skid_vld   <= 1'b0;
            end
         end else if (w_deliver) begin
            if (w_to_skid) begin
               r_skid_vld   <= 1'b1;
               r_skid_instr <= imem_rdata;
               r_skid_pc    <= r_tag_pc;
            end else begin
               r_ifid_valid <= 1'b1;
               r_ifid_instr <= imem_rdata;
               r_ifid_pc    <= r_tag_pc;
               r_ifid_pc4   <= r_tag_pc + ADDR_W'(4);
            end
         end else if (~id_stall) begin
            r_ifid_valid <= 1'b0;
         end
      end
   end

`ifdef IF_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [1:0]  w_inc;

   // fetch-wait and decode-hold cycles both count, so one cycle may add 2
   assign w_inc = 2'((r_state != IDLE) & ~w_accept) + 2'(r_ifid_valid & id_stall);
   assign if_stall_cnt = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (r_stall_cnt > 32'hFFFF_FFFF - 32'(w_inc))
         r_stall_cnt <= 32'hFFFF_FFFF;
      else
         r_stall_cnt <= r_stall_cnt + 32'(w_inc);
   end
`endif

endmodule
